lamp_sequence_monitor: RTL and testbench
========================================

// Module: lamp_sequence_monitor
// PURPOSE
//  Passive checker on the traffic-light controller outputs. Decodes traffic_lights/pedestrian_lights back into
//  controller phase, measures phase dwell in clk cycles (1 ms at 1 kHz), flags conflicts, illegal transitions
//  and timing violations. Sits beside the controller; drives no lamps.
// PARAMETERS
//  RED_MS        30000  max RED dwell (exact when exiting to RED_AMBER)
//  RED_AMBER_MS  3000   exact RED_AMBER dwell
//  GREEN_MS      30000  max GREEN dwell (exact when exiting to AMBER with no ped request)
//  AMBER_MS      3000   exact AMBER dwell
//  PED_GREEN_MS  30000  exact PED_GREEN dwell
//  TOL_MS        2      +/- tolerance applied to every dwell check
// PORTS
//  clk                input   1   system clock, 1 kHz
//  rst                input   1   asynchronous reset, active-high
//  traffic_lights     input   3   {R,A,G}: 100 RED, 110 RED_AMBER, 001 GREEN, 010 AMBER
//  pedestrian_lights  input   2   {R,G}: 10 RED, 01 GREEN
//  err_clr            input   1   synchronous clear of sticky errors
//  phase              output  3   0 RED,1 RED_AMBER,2 GREEN,3 AMBER,4 PED_GREEN,7 INVALID
//  phase_valid        output  1   1 when phase != INVALID and not in startup
//  err_any            output  1   OR of sticky error flags
//  err_code           output  3   first error since clear: 0 none,1 conflict,2 illegal,3 short,4 long
//  ped_cycles         output  8   PED_GREEN entries, saturates at 255
// BEHAVIOUR
//  - Inputs registered once (sample stage); decode+check registered: outputs lag input change by 2 clk edges.
//  - Decode: {100,10}->RED, {110,10}->RED_AMBER, {001,10}->GREEN, {010,10}->AMBER, {100,01}->PED_GREEN;
//    any other combination -> INVALID (conflict).
//  - Reset: phase=7, phase_valid=0, err_any=0, err_code=0, ped_cycles=0, dwell=0, startup=1.
//  - Dwell counter: 16 b, =1 on first cycle of a new sampled phase, +1 per cycle held, saturates 0xFFFF.
//  - Legal transitions only: RED->RED_AMBER, RED->PED_GREEN, RED_AMBER->GREEN, GREEN->AMBER,
//    AMBER->RED, AMBER->PED_GREEN, PED_GREEN->RED_AMBER. Any other valid->valid change: error 2.
//  - Entering INVALID: error 1. Leaving INVALID, and first phase after reset (startup): no transition or
//    dwell check on that entry/exit; startup clears at the first subsequent phase change.
//  - Short check at exit (dwell < nominal-TOL): error 3. Exact phases RED_AMBER, AMBER, PED_GREEN always;
//    RED only when exiting to RED_AMBER; GREEN never (ped request may shorten GREEN/RED).
//  - Long check live: dwell reaches max+TOL+1 in current phase -> error 4, flagged once per phase visit.
//  - Simultaneous events in one cycle: err_code priority 1 > 2 > 3 > 4; err_code holds first error until clear.
//  - err_clr: clears err_any/err_code next edge; an error event in the same cycle wins (stays set, new code).
//  - ped_cycles increments on every valid entry to PED_GREEN (incl. startup entry); cleared only by rst.
//  - rst mid-phase: all state to reset values; monitor resumes in startup.
// CONFIGURATION
//  LSM_ERR_CAPTURE_EN defined: adds outputs err_from[2:0], err_to[2:0], err_dwell[15:0], loaded with
//   previous phase, new phase and dwell at the event that sets err_code from 0; held until err_clr; 0 at reset.
//  Not defined: those ports and registers absent; all other behaviour identical.
// TESTING (sim with RED_MS=30, RED_AMBER_MS=3, GREEN_MS=30, AMBER_MS=3, PED_GREEN_MS=30, TOL_MS=2)
//  - Drive nominal loop RED30/RA3/G30/A3 twice -> err_any=0, phase tracks 0,1,2,3 with 2-cycle lag.
//  - RED 15 -> PED_GREEN 30 -> RED_AMBER, and GREEN 15 -> AMBER 3 -> PED_GREEN -> err_any=0, ped_cycles=2.
//  - Drive {001,01} one cycle -> phase=7, err_code=1; err_clr pulse -> err_code=0, err_any=0.
//  - GREEN -> RED directly after full dwell -> err_code=2; with LSM_ERR_CAPTURE_EN err_from=2, err_to=0.
//  - AMBER held 1 cycle -> err_code=3; PED_GREEN held 40 -> err_code=4 raised at dwell 33, once.
//  - Conflict and illegal change same cycle plus err_clr asserted -> err_code=1; rst mid-GREEN -> all outputs reset.

Source files
------------

// File: rtl/lamp_sequence_monitor.sv
// lamp_sequence_monitor: passive checker on the traffic-light controller lamp outputs.
// Decodes the lamps back into the controller phase, measures phase dwell in clk cycles
// and flags conflicts, illegal transitions, short dwells and long dwells.
// Optional feature macro LSM_ERR_CAPTURE_EN adds err_from/err_to/err_dwell, a snapshot
// of the event that raised the first error since the last clear.
// Ports:
//   clk                1 kHz system clock
//   rst                asynchronous active-high reset
//   traffic_lights     {R,A,G} vehicle lamps
//   pedestrian_lights  {R,G} pedestrian lamps
//   err_clr            synchronous clear of the sticky error state
//   phase              0 RED, 1 RED_AMBER, 2 GREEN, 3 AMBER, 4 PED_GREEN, 7 INVALID
//   phase_valid        phase is not INVALID and the startup phase has been left
//   err_any            any sticky error present
//   err_code           first error since clear: 1 conflict, 2 illegal, 3 short, 4 long
//   ped_cycles         saturating count of PED_GREEN entries
module lamp_sequence_monitor #(
    parameter int RED_MS       = 30000,
    parameter int RED_AMBER_MS = 3000,
    parameter int GREEN_MS     = 30000,
    parameter int AMBER_MS     = 3000,
    parameter int PED_GREEN_MS = 30000,
    parameter int TOL_MS       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  traffic_lights,
    input  logic [1:0]  pedestrian_lights,
    input  logic        err_clr,
    output logic [2:0]  phase,
    output logic        phase_valid,
    output logic        err_any,
    output logic [2:0]  err_code,
    output logic [7:0]  ped_cycles
`ifdef LSM_ERR_CAPTURE_EN
    ,
    output logic [2:0]  err_from,
    output logic [2:0]  err_to,
    output logic [15:0] err_dwell
`endif
);
    typedef enum logic [2:0] {
        PH_RED   = 3'd0,
        PH_RA    = 3'd1,
        PH_GREEN = 3'd2,
        PH_AMBER = 3'd3,
        PH_PED   = 3'd4,
        PH_INV   = 3'd7
    } phase_t;

    phase_t      phase_q, dec;
    logic [2:0]  s_tl;
    logic [1:0]  s_pl;
    logic [15:0] dwell, dwell_nx;
    logic        startup, long_done, change, checked, short_app;
    logic        ev_conf, ev_ill, ev_short, ev_long, load;
    logic [2:0]  ev;

    // Nominal (exact) or maximum dwell of a phase; 17 bits so tolerance sums cannot wrap.
    function automatic logic [16:0] nom(input phase_t p);
        return p == PH_RED   ? 17'(RED_MS) :
               p == PH_RA    ? 17'(RED_AMBER_MS) :
               p == PH_GREEN ? 17'(GREEN_MS) :
               p == PH_AMBER ? 17'(AMBER_MS) : 17'(PED_GREEN_MS);
    endfunction

    function automatic logic legal(input phase_t f, input phase_t t);
        return (f == PH_RED   && (t == PH_RA || t == PH_PED)) ||
               (f == PH_RA    && t == PH_GREEN) ||
               (f == PH_GREEN && t == PH_AMBER) ||
               (f == PH_AMBER && (t == PH_RED || t == PH_PED)) ||
               (f == PH_PED   && t == PH_RA);
    endfunction

    always_comb begin
        dec = PH_INV;
        if (s_pl == 2'b10)
            dec = s_tl == 3'b100 ? PH_RED :
                  s_tl == 3'b110 ? PH_RA :
                  s_tl == 3'b001 ? PH_GREEN :
                  s_tl == 3'b010 ? PH_AMBER : PH_INV;
        else if (s_pl == 2'b01 && s_tl == 3'b100)
            dec = PH_PED;
    end

    always_comb begin
        change    = dec != phase_q;
        // Exits from INVALID and from the startup phase carry no timing/sequence history.
        checked   = change && !startup && phase_q != PH_INV;
        dwell_nx  = change ? 16'd1 : (&dwell ? dwell : dwell + 16'd1);
        // GREEN and RED may be cut short by a pedestrian request, so only exact phases
        // (and RED when it runs its full course into RED_AMBER) get a short check.
        short_app = phase_q == PH_RA || phase_q == PH_AMBER || phase_q == PH_PED ||
                    (phase_q == PH_RED && dec == PH_RA);
        ev_conf   = change && dec == PH_INV;
        ev_ill    = checked && dec != PH_INV && !legal(phase_q, dec);
        ev_short  = checked && short_app && ({1'b0, dwell} + 17'(TOL_MS) < nom(phase_q));
        ev_long   = !change && !startup && phase_q != PH_INV && !long_done &&
                    ({1'b0, dwell_nx} >= nom(phase_q) + 17'(TOL_MS) + 17'd1);
        ev        = ev_conf ? 3'd1 : ev_ill ? 3'd2 : ev_short ? 3'd3 : ev_long ? 3'd4 : 3'd0;
        // A new event wins over a simultaneous clear.
        load      = ev != 3'd0 && (err_code == 3'd0 || err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_tl       <= 3'd0;
            s_pl       <= 2'd0;
            phase_q    <= PH_INV;
            dwell      <= 16'd0;
            startup    <= 1'b1;
            long_done  <= 1'b0;
            err_code   <= 3'd0;
            ped_cycles <= 8'd0;
        end else begin
            s_tl      <= traffic_lights;
            s_pl      <= pedestrian_lights;
            phase_q   <= dec;
            dwell     <= dwell_nx;
            startup   <= startup && !(change && phase_q != PH_INV);
            long_done <= change ? 1'b0 : (long_done | ev_long);
            err_code  <= load ? ev : (err_clr ? 3'd0 : err_code);
            if (change && dec == PH_PED && !(&ped_cycles))
                ped_cycles <= ped_cycles + 8'd1;
        end
    end

`ifdef LSM_ERR_CAPTURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_from  <= 3'd0;
            err_to    <= 3'd0;
            err_dwell <= 16'd0;
        end else if (load) begin
            err_from  <= phase_q;
            err_to    <= dec;
            err_dwell <= change ? dwell : dwell_nx;
        end else if (err_clr) begin
            err_from  <= 3'd0;
            err_to    <= 3'd0;
            err_dwell <= 16'd0;
        end
    end
`endif

    assign phase       = phase_q;
    assign phase_valid = phase_q != PH_INV && !startup;
    assign err_any     = err_code != 3'd0;
endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// tb_lamp_sequence_monitor: directed and randomized lamp sequences against a phase-level reference model.
module tb_lamp_sequence_monitor;
    localparam logic [4:0] L_RED = 5'b100_10;
    localparam logic [4:0] L_RA  = 5'b110_10;
    localparam logic [4:0] L_G   = 5'b001_10;
    localparam logic [4:0] L_A   = 5'b010_10;
    localparam logic [4:0] L_PED = 5'b100_01;
    localparam logic [4:0] PATS [5] = '{L_RED, L_RA, L_G, L_A, L_PED};
    // Allowed successors of each phase as a bit mask over phase numbers.
    localparam logic [4:0] SUCC [5] = '{5'b10010, 5'b00100, 5'b01000, 5'b10001, 5'b00010};
    localparam int NOM [5] = '{30, 3, 30, 3, 30};
    localparam int TOL = 2;

    logic       clk = 1'b0, rst = 1'b1, err_clr = 1'b0;
    logic [2:0] tl = 3'b100;
    logic [1:0] pl = 2'b10;
    logic [2:0] phase, err_code;
    logic       phase_valid, err_any;
    logic [7:0] ped_cycles;
`ifdef LSM_ERR_CAPTURE_EN
    logic [2:0]  err_from, err_to;
    logic [15:0] err_dwell;
`endif

    int checks = 0, failures = 0;
    logic [4:0] mq;
    int  m_phase, m_len, m_ped, m_code;
    bit  m_start, m_long;

    lamp_sequence_monitor #(
        .RED_MS(30), .RED_AMBER_MS(3), .GREEN_MS(30), .AMBER_MS(3), .PED_GREEN_MS(30), .TOL_MS(2)
    ) dut (
        .clk(clk), .rst(rst), .traffic_lights(tl), .pedestrian_lights(pl), .err_clr(err_clr),
        .phase(phase), .phase_valid(phase_valid), .err_any(err_any), .err_code(err_code),
        .ped_cycles(ped_cycles)
`ifdef LSM_ERR_CAPTURE_EN
        , .err_from(err_from), .err_to(err_to), .err_dwell(err_dwell)
`endif
    );

    always #5 clk = ~clk;

    function automatic int decode(input logic [4:0] v);
        for (int i = 0; i < 5; i++)
            if (v == PATS[i]) return i;
        return 7;
    endfunction

    task automatic model_reset();
        mq = 5'd0; m_phase = 7; m_len = 0; m_ped = 0; m_code = 0; m_start = 1; m_long = 0;
    endtask

    // One clock edge of the reference: the phase seen now is the lamps captured one edge earlier.
    task automatic model_edge(input logic [4:0] v, input bit clr);
        int np, ev;
        bit chk;
        np = decode(mq);
        mq = v;
        ev = 0;
        if (np != m_phase) begin
            chk = !m_start && m_phase != 7;
            if (np == 7) ev = 1;
            else if (chk) begin
                if (!SUCC[m_phase][np]) ev = 2;
                else if (m_phase != 2 && (m_phase != 0 || np == 1) && m_len < NOM[m_phase] - TOL) ev = 3;
            end
            if (ev != 1 && ev != 2 && chk && m_phase != 2 && (m_phase != 0 || np == 1) &&
                m_len < NOM[m_phase] - TOL) ev = 3;
            if (m_start && m_phase != 7) m_start = 0;
            if (np == 4 && m_ped < 255) m_ped++;
            m_phase = np; m_len = 1; m_long = 0;
        end else begin
            if (m_len < 65535) m_len++;
            if (!m_start && m_phase != 7 && !m_long && m_len == NOM[m_phase] + TOL + 1) begin
                ev = 4; m_long = 1;
            end
        end
        if (ev != 0 && (m_code == 0 || clr)) m_code = ev;
        else if (clr) m_code = 0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("phase", 16'(phase), 16'(m_phase));
        chk("phase_valid", 16'(phase_valid), 16'(m_phase != 7 && !m_start));
        chk("err_code", 16'(err_code), 16'(m_code));
        chk("err_any", 16'(err_any), 16'(m_code != 0));
        chk("ped_cycles", 16'(ped_cycles), 16'(m_ped));
    endtask

    task automatic step(input logic [4:0] v, input bit clr);
        {tl, pl} = v;
        err_clr = clr;
        @(posedge clk);
        model_edge(v, clr);
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(input logic [4:0] v, input int n);
        repeat (n) step(v, 1'b0);
    endtask

    initial begin
        int p, d, nxt;
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        // Nominal loop twice, with the two-edge lag checked explicitly on the first RED->RED_AMBER.
        hold(L_RED, 20);
        step(L_RA, 1'b0);
        chk("lag_one_edge", 16'(phase), 16'd0);
        step(L_RA, 1'b0);
        chk("lag_two_edges", 16'(phase), 16'd1);
        step(L_RA, 1'b0);
        hold(L_G, 30); hold(L_A, 3); hold(L_RED, 30);
        hold(L_RA, 3); hold(L_G, 30); hold(L_A, 3); hold(L_RED, 30);
        chk("nominal_err_any", 16'(err_any), 16'd0);
        // Pedestrian paths from RED and from AMBER.
        hold(L_RA, 3); hold(L_G, 30); hold(L_A, 3); hold(L_RED, 15); hold(L_PED, 30);
        hold(L_RA, 3); hold(L_G, 15); hold(L_A, 3); hold(L_PED, 30); hold(L_RA, 3); hold(L_G, 5);
        chk("ped_err_any", 16'(err_any), 16'd0);
        chk("ped_two_entries", 16'(ped_cycles), 16'd2);
        // Conflict, then clear.
        step(5'b001_01, 1'b0);
        step(L_G, 1'b0);
        chk("conflict_phase", 16'(phase), 16'd7);
        chk("conflict_code", 16'(err_code), 16'd1);
        step(L_G, 1'b1);
        chk("clear_code", 16'(err_code), 16'd0);
        chk("clear_any", 16'(err_any), 16'd0);
        // GREEN straight to RED.
        hold(L_G, 26);
        hold(L_RED, 2);
        chk("illegal_code", 16'(err_code), 16'd2);
`ifdef LSM_ERR_CAPTURE_EN
        chk("capture_from", 16'(err_from), 16'd2);
        chk("capture_to", 16'(err_to), 16'd0);
`endif
        step(L_RED, 1'b1);
        // Short PED_GREEN, then an overlong PED_GREEN flagged once.
        hold(L_RED, 26); hold(L_PED, 10); hold(L_RA, 2);
        chk("short_code", 16'(err_code), 16'd3);
        step(L_RA, 1'b1);
        hold(L_G, 30); hold(L_A, 3); hold(L_PED, 33);
        chk("long_not_yet", 16'(err_code), 16'd0);
        step(L_PED, 1'b0);
        chk("long_code", 16'(err_code), 16'd4);
        step(L_PED, 1'b1);
        hold(L_PED, 5);
        chk("long_once", 16'(err_code), 16'd0);
        // Conflict beats a simultaneous clear of an existing error.
        hold(L_RA, 3); hold(L_G, 10); hold(L_RED, 2);
        step(5'b110_01, 1'b0);
        step(L_RED, 1'b1);
        chk("conflict_over_clear", 16'(err_code), 16'd1);
        // Asynchronous reset in the middle of GREEN.
        hold(L_RED, 28); hold(L_RA, 3); hold(L_G, 10);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("reset_ped_cycles", 16'(ped_cycles), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        // Saturation of the PED_GREEN entry counter.
        for (int i = 0; i < 260; i++) begin
            step(L_A, 1'b0); step(L_PED, 1'b0); step(L_RA, 1'b0); step(L_G, 1'b0);
        end
        chk("ped_saturate", 16'(ped_cycles), 16'd255);
        step(L_G, 1'b1);
        // Randomized phase walks with off-nominal dwells, glitches and clears.
        p = 2;
        repeat (60) begin
            d = $urandom_range(0, 9);
            if (d == 0) step(5'($urandom), 1'b0);
            if (d == 1) nxt = $urandom_range(0, 4);
            else begin
                do nxt = $urandom_range(0, 4); while (!SUCC[p][nxt]);
            end
            d = NOM[nxt] + $urandom_range(0, 10) - 6;
            if (d < 1) d = 1;
            for (int i = 0; i < d; i++) step(PATS[nxt], $urandom_range(0, 15) == 0);
            p = nxt;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
